// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forward-select encoding: FWD_NONE means "use the register file value",
//     fwd_src(k) selects forwarding source k (0 = youngest, MEM).
//   - reg_addr_t: architectural register address for the default 32-entry file.
// Optional feature macro used by this slice: HAZARD_PERF_EN.
package hazard_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_RA_W     = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_RA_W-1:0] reg_addr_t;

  localparam int FWD_NONE = 0;

  function automatic int fwd_src(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy-bit tracking for variable-latency results.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   start_i / start_rd_i        op committed out of EX, marks its destination busy
//   done_i / done_rd_i          write-back of a variable-latency result
//   busy_o                      per-register busy vector (bit 0 is always 0)
//   full_o                      in-flight count has reached MAX_OUTST
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int MAX_OUTST = 4,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int OC_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [RA_W-1:0]     start_rd_i,
  input  logic                done_i,
  input  logic [RA_W-1:0]     done_rd_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                full_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [OC_W-1:0]     cnt_q, cnt_d;
  logic                set_en, clr_en;

  // x0 is never tracked; a done for a register that is not busy (e.g. a late
  // pulse after reset) is ignored so the count cannot drift.
  assign set_en = start_i & (start_rd_i != '0);
  assign clr_en = done_i & busy_q[done_rd_i];

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[done_rd_i] = 1'b0;
    // Set is applied last so a same-register start/done leaves the bit set.
    if (set_en) busy_d[start_rd_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (set_en && !clr_en) begin
      if (cnt_q != OC_W'(MAX_OUTST)) cnt_d = cnt_q + OC_W'(1);
    end else if (clr_en && !set_en) begin
      if (cnt_q != '0) cnt_d = cnt_q - OC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && done_i) begin
      assert (busy_q[done_rd_i])
        else $warning("%m: completion for register %0d that is not busy", done_rd_i);
    end
  end

  assign busy_o = busy_q;
  assign full_o = (cnt_q == OC_W'(MAX_OUTST));

endmodule

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: stall/flush/forward controller for the 5-stage pipeline,
// with a register scoreboard for variable-latency units.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   instr_hit_fi_i                 I-cache hit in fetch
//   rs1/rs2/rd_de_i, mc_op_de_i    decode operands, decode op is variable-latency
//   rs1/rs2/rd_ex_i, load_ex_i     EX operands/destination, EX op is a load
//   fwd_rd_i, fwd_we_i             per-source destination/write enable (idx 0 youngest)
//   mc_start_i/_rd_i, mc_done_i/_rd_i  scoreboard set / clear
//   redirect_i, redirect_reg_i, ic_repl_permit_i  redirect control
//   stall_*_o, flush_de_o, flush_ex_o  stage control
//   fwd_a_sel_o, fwd_b_sel_o       0 = no forward, k+1 = source k
//   sb_full_o                      in-flight limit reached
//   perf_load_stall_o, perf_sb_stall_o  cycle counters (only with HAZARD_PERF_EN)
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int NUM_FWD   = 2,
  parameter int NUM_REGS  = 32,
  parameter int MAX_OUTST = 4,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    instr_hit_fi_i,
  input  logic [RA_W-1:0]         rs1_de_i,
  input  logic [RA_W-1:0]         rs2_de_i,
  input  logic [RA_W-1:0]         rd_de_i,
  input  logic                    mc_op_de_i,
  input  logic [RA_W-1:0]         rs1_ex_i,
  input  logic [RA_W-1:0]         rs2_ex_i,
  input  logic [RA_W-1:0]         rd_ex_i,
  input  logic                    load_ex_i,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic                    mc_start_i,
  input  logic [RA_W-1:0]         mc_start_rd_i,
  input  logic                    mc_done_i,
  input  logic [RA_W-1:0]         mc_done_rd_i,
  input  logic                    redirect_i,
  input  logic                    redirect_reg_i,
  input  logic                    ic_repl_permit_i,
  output logic                    stall_fi_o,
  output logic                    stall_de_o,
  output logic                    stall_ex_o,
  output logic                    stall_mem_o,
  output logic                    stall_wb_o,
  output logic                    flush_de_o,
  output logic                    flush_ex_o,
  output logic [SEL_W-1:0]        fwd_a_sel_o,
  output logic [SEL_W-1:0]        fwd_b_sel_o,
  output logic                    sb_full_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             perf_load_stall_o,
  output logic [31:0]             perf_sb_stall_o
`endif
);

  logic [NUM_REGS-1:0] busy;
  logic                load_stall, sb_stall, hazard_stall;

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .MAX_OUTST (MAX_OUTST)
  ) u_sb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (mc_start_i),
    .start_rd_i (mc_start_rd_i),
    .done_i     (mc_done_i),
    .done_rd_i  (mc_done_rd_i),
    .busy_o     (busy),
    .full_o     (sb_full_o)
  );

  // busy[0] is never set, so x0 operands cannot stall here.
  assign sb_stall = busy[rs1_de_i] | busy[rs2_de_i] | busy[rd_de_i]
                  | (mc_op_de_i & sb_full_o);

  assign load_stall = load_ex_i & (rd_ex_i != '0)
                    & ((rs1_de_i == rd_ex_i) | (rs2_de_i == rd_ex_i));

  assign hazard_stall = load_stall | sb_stall;

  assign stall_de_o  = hazard_stall | ~instr_hit_fi_i;
  assign stall_fi_o  = stall_de_o & ~redirect_reg_i;
  assign stall_ex_o  = ~instr_hit_fi_i;
  assign stall_mem_o = ~instr_hit_fi_i;
  assign stall_wb_o  = ~instr_hit_fi_i;

  assign flush_de_o = redirect_i;
  assign flush_ex_o = (redirect_i & (ic_repl_permit_i | redirect_reg_i)) | hazard_stall;

  // Scan oldest to youngest so the youngest matching source is assigned last.
  always_comb begin
    fwd_a_sel_o = SEL_W'(FWD_NONE);
    fwd_b_sel_o = SEL_W'(FWD_NONE);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we_i[k] && (fwd_rd_i[k*RA_W +: RA_W] == rs1_ex_i) && (rs1_ex_i != '0))
        fwd_a_sel_o = SEL_W'(fwd_src(k));
      if (fwd_we_i[k] && (fwd_rd_i[k*RA_W +: RA_W] == rs2_ex_i) && (rs2_ex_i != '0))
        fwd_b_sel_o = SEL_W'(fwd_src(k));
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_q, perf_load_d;
  logic [31:0] perf_sb_q, perf_sb_d;

  assign perf_load_d = load_stall ? perf_load_q + 32'd1 : perf_load_q;
  assign perf_sb_d   = sb_stall   ? perf_sb_q   + 32'd1 : perf_sb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_load_q <= '0;
      perf_sb_q   <= '0;
    end else begin
      perf_load_q <= perf_load_d;
      perf_sb_q   <= perf_sb_d;
    end
  end

  assign perf_load_stall_o = perf_load_q;
  assign perf_sb_stall_o   = perf_sb_q;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
module tb_hazard_unit_sb;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       instr_hit_fi_i;
  logic [4:0] rs1_de_i, rs2_de_i, rd_de_i;
  logic       mc_op_de_i;
  logic [4:0] rs1_ex_i, rs2_ex_i, rd_ex_i;
  logic       load_ex_i;
  logic [9:0] fwd_rd_i;
  logic [1:0] fwd_we_i;
  logic       mc_start_i;
  logic [4:0] mc_start_rd_i;
  logic       mc_done_i;
  logic [4:0] mc_done_rd_i;
  logic       redirect_i, redirect_reg_i, ic_repl_permit_i;
  logic       stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o;
  logic       flush_de_o, flush_ex_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       sb_full_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_stall_o, perf_sb_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_unit_sb dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .instr_hit_fi_i   (instr_hit_fi_i),
    .rs1_de_i         (rs1_de_i),
    .rs2_de_i         (rs2_de_i),
    .rd_de_i          (rd_de_i),
    .mc_op_de_i       (mc_op_de_i),
    .rs1_ex_i         (rs1_ex_i),
    .rs2_ex_i         (rs2_ex_i),
    .rd_ex_i          (rd_ex_i),
    .load_ex_i        (load_ex_i),
    .fwd_rd_i         (fwd_rd_i),
    .fwd_we_i         (fwd_we_i),
    .mc_start_i       (mc_start_i),
    .mc_start_rd_i    (mc_start_rd_i),
    .mc_done_i        (mc_done_i),
    .mc_done_rd_i     (mc_done_rd_i),
    .redirect_i       (redirect_i),
    .redirect_reg_i   (redirect_reg_i),
    .ic_repl_permit_i (ic_repl_permit_i),
    .stall_fi_o       (stall_fi_o),
    .stall_de_o       (stall_de_o),
    .stall_ex_o       (stall_ex_o),
    .stall_mem_o      (stall_mem_o),
    .stall_wb_o       (stall_wb_o),
    .flush_de_o       (flush_de_o),
    .flush_ex_o       (flush_ex_o),
    .fwd_a_sel_o      (fwd_a_sel_o),
    .fwd_b_sel_o      (fwd_b_sel_o),
    .sb_full_o        (sb_full_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_load_stall_o (perf_load_stall_o),
    .perf_sb_stall_o   (perf_sb_stall_o)
`endif
  );

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // {stall_fi, stall_de, stall_ex, stall_mem, stall_wb, flush_de, flush_ex, sb_full, a_sel, b_sel}
  function automatic logic [11:0] pk(input logic fi, input logic de, input logic ex,
                                     input logic fde, input logic fex, input logic full,
                                     input logic [1:0] a, input logic [1:0] b);
    return {fi, de, ex, ex, ex, fde, fex, full, a, b};
  endfunction

  // Inputs are driven just after a falling edge; outputs are sampled 2 time
  // units later, before the next rising edge commits scoreboard updates.
  task automatic step(input string tag, input logic [11:0] e);
    exp_t        x;
    logic [11:0] obs;
    q.push_back('{tag, e});
    #2;
    obs = {stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o,
           flush_de_o, flush_ex_o, sb_full_o, fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      x = q.pop_front();
      assert (obs === x.v)
        else begin
          errors++;
          $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
        end
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    instr_hit_fi_i   = 1'b1;
    rs1_de_i = '0; rs2_de_i = '0; rd_de_i = '0;
    mc_op_de_i       = 1'b0;
    rs1_ex_i = '0; rs2_ex_i = '0; rd_ex_i = '0;
    load_ex_i        = 1'b0;
    fwd_rd_i         = '0;
    fwd_we_i         = '0;
    mc_start_i       = 1'b0;
    mc_start_rd_i    = '0;
    mc_done_i        = 1'b0;
    mc_done_rd_i     = '0;
    redirect_i       = 1'b0;
    redirect_reg_i   = 1'b0;
    ic_repl_permit_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  localparam logic [11:0] ZERO = 12'h000;

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    step("reset_idle", ZERO);
    instr_hit_fi_i = 1'b0;
    step("icache_miss", pk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0));
    instr_hit_fi_i = 1'b1;

    // Forwarding priority
    fwd_rd_i = {5'd5, 5'd5}; fwd_we_i = 2'b11; rs1_ex_i = 5'd5;
    step("fwd_youngest", pk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0));
    fwd_we_i = 2'b10;
    step("fwd_wb_only", pk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0));
    rs1_ex_i = 5'd0; fwd_rd_i = '0; fwd_we_i = 2'b11;
    step("fwd_x0", ZERO);
    fwd_rd_i = {5'd3, 5'd4}; rs1_ex_i = 5'd3; rs2_ex_i = 5'd4;
    step("fwd_both_ops", pk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1));
    fwd_we_i = 2'b00;
    step("fwd_no_we", ZERO);
    idle_inputs();

    // Load-use
    load_ex_i = 1'b1; rd_ex_i = 5'd7; rs2_de_i = 5'd7;
    step("load_use_rs2", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    rs2_de_i = 5'd0; rs1_de_i = 5'd7;
    step("load_use_rs1", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    rd_ex_i = 5'd0; rs1_de_i = 5'd0;
    step("load_rd_x0", ZERO);
    idle_inputs();

    // Scoreboard RAW on x9
    mc_start_i = 1'b1; mc_start_rd_i = 5'd9;
    step("raw_start", ZERO);
    mc_start_i = 1'b0; rs1_de_i = 5'd9;
    for (int i = 1; i <= 3; i++)
      step($sformatf("raw_wait%0d", i), pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    mc_done_i = 1'b1; mc_done_rd_i = 5'd9;
    step("raw_done_cycle", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    mc_done_i = 1'b0;
    step("raw_released", ZERO);
    idle_inputs();

    // x0 destination is never tracked
    mc_start_i = 1'b1; mc_start_rd_i = 5'd0;
    step("start_x0", ZERO);
    mc_start_i = 1'b0;
    step("x0_not_busy", ZERO);

    // Fill to MAX_OUTST
    for (int r = 1; r <= 4; r++) begin
      mc_start_i = 1'b1; mc_start_rd_i = 5'(r);
      step($sformatf("fill_x%0d", r), ZERO);
    end
    mc_start_i = 1'b0; mc_op_de_i = 1'b1;
    step("full_mc_op_stall", pk(1, 1, 0, 0, 1, 1, 2'd0, 2'd0));
    mc_op_de_i = 1'b0;
    mc_start_i = 1'b1; mc_start_rd_i = 5'd6; mc_done_i = 1'b1; mc_done_rd_i = 5'd1;
    step("full_swap", pk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0));
    mc_start_i = 1'b0; mc_done_i = 1'b0;
    step("full_held", pk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0));
    rs1_de_i = 5'd6;
    step("full_x6_busy", pk(1, 1, 0, 0, 1, 1, 2'd0, 2'd0));
    rs1_de_i = 5'd1;
    step("full_x1_free", pk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0));
    rs1_de_i = 5'd0;
    mc_done_i = 1'b1;
    mc_done_rd_i = 5'd2; step("drain_x2", pk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0));
    mc_done_rd_i = 5'd3; step("drain_x3", ZERO);
    mc_done_rd_i = 5'd4; step("drain_x4", ZERO);
    mc_done_rd_i = 5'd6; step("drain_x6", ZERO);
    mc_done_i = 1'b0;
    rs1_de_i = 5'd6; rs2_de_i = 5'd2;
    step("drained", ZERO);
    idle_inputs();

    // Same-cycle start/done on x3
    mc_start_i = 1'b1; mc_start_rd_i = 5'd3;
    step("x3_start", ZERO);
    mc_done_i = 1'b1; mc_done_rd_i = 5'd3;
    step("x3_start_done", ZERO);
    mc_start_i = 1'b0; mc_done_i = 1'b0; rd_de_i = 5'd3;
    step("x3_waw_busy", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    mc_done_i = 1'b1; rd_de_i = 5'd0; rs2_de_i = 5'd3;
    step("x3_done", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    mc_done_i = 1'b0;
    step("x3_free", ZERO);
    idle_inputs();

    // Redirects
    redirect_i = 1'b1; redirect_reg_i = 1'b1; instr_hit_fi_i = 1'b0;
    step("redirect_miss", pk(0, 1, 1, 1, 1, 0, 2'd0, 2'd0));
    redirect_reg_i = 1'b0; instr_hit_fi_i = 1'b1;
    step("redirect_no_permit", pk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
    ic_repl_permit_i = 1'b1;
    step("redirect_permit", pk(0, 0, 0, 1, 1, 0, 2'd0, 2'd0));
    idle_inputs();

    // Reset while x8 busy
    mc_start_i = 1'b1; mc_start_rd_i = 5'd8;
    step("x8_start", ZERO);
    mc_start_i = 1'b0; rs1_de_i = 5'd8; reset_i = 1'b1;
    step("x8_busy_in_reset", pk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0));
    reset_i = 1'b0;
    step("x8_cleared", ZERO);

    if (q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expectations observed=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Next-generation pipeline hazard controller.
- Adds a register scoreboard for variable-latency units (mul/div, non-blocking loads).
- Generalises forwarding to NUM_FWD write-back sources with a parametrised select encoding.
- Sits beside the 5-stage datapath. Drives all stage stalls and flushes plus the operand forward selects for EX.

Parameters:
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest (MEM), then WB, and so on.
- NUM_REGS, 32, architectural register count.
- MAX_OUTST, 4, maximum in-flight variable-latency ops.
- Derived: RA_W = $clog2(NUM_REGS); SEL_W = $clog2(NUM_FWD+1); OC_W = $clog2(MAX_OUTST+1).

Ports:
- clk_i in 1: clock.
- reset_i in 1: synchronous active-high reset.
- instr_hit_fi_i in 1: I-cache hit.
- rs1_de_i, rs2_de_i, rd_de_i in RA_W: decode operand addresses.
- mc_op_de_i in 1: decode instruction is variable-latency.
- rs1_ex_i, rs2_ex_i, rd_ex_i in RA_W: EX operand/destination addresses.
- load_ex_i in 1: EX instruction is a load.
- fwd_rd_i in NUM_FWD*RA_W: packed destination address per forwarding source.
- fwd_we_i in NUM_FWD: per-source register write enable.
- mc_start_i in 1: variable-latency op leaves EX, committed.
- mc_start_rd_i in RA_W: its destination.
- mc_done_i in 1: result write-back pulse.
- mc_done_rd_i in RA_W: destination being completed.
- redirect_i in 1: taken redirect resolved in EX.
- redirect_reg_i in 1: registered redirect.
- ic_repl_permit_i in 1: I-cache replacement permitted.
- stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o out 1: stage stalls.
- flush_de_o, flush_ex_o out 1: stage flushes.
- fwd_a_sel_o, fwd_b_sel_o out SEL_W: operand forward selects.
- sb_full_o out 1: in-flight counter at MAX_OUTST.

Behaviour:
- Clock/reset: one clock clk_i; reset_i is synchronous, active-high.
- Reset: busy vector, outst_cnt and perf counters are cleared.
- All outputs are combinational from inputs and state, so they are 0 once reset state is loaded, apart from the ~instr_hit term.
- Scoreboard set: mc_start_i sets busy[mc_start_rd_i]; rd=0 is never set.
- Scoreboard clear: mc_done_i clears busy[mc_done_rd_i].
- Same-cycle start and done:
  - Same register: start wins, so busy stays 1.
  - Different registers: both take effect.
- Done on a non-busy register: no change. Assertion flags it in simulation.
- outst_cnt: +1 on start, -1 on done, unchanged on both. Saturating, no wrap.
- sb_full_o = (outst_cnt == MAX_OUTST).
- sb_stall = busy[rs1_de_i] | busy[rs2_de_i] | busy[rd_de_i] (WAW) | (mc_op_de_i & sb_full_o). Register x0 never stalls.
- load_stall = load_ex_i & rd_ex_i != 0 & (rs1_de_i == rd_ex_i | rs2_de_i == rd_ex_i).
- Stall outputs:
  - stall_fi_o = (load_stall | sb_stall | ~instr_hit_fi_i) & ~redirect_reg_i.
  - stall_de_o = load_stall | sb_stall | ~instr_hit_fi_i.
  - stall_ex_o = stall_mem_o = stall_wb_o = ~instr_hit_fi_i.
- Flush outputs:
  - flush_de_o = redirect_i.
  - flush_ex_o = (redirect_i & (ic_repl_permit_i | redirect_reg_i)) | load_stall | sb_stall.
- Forward select per operand:
  - Lowest index k with fwd_we_i[k] & fwd_rd[k] == rs & rs != 0 gives sel = k+1.
  - No match gives sel = 0. The youngest source always wins.
- Forwarding never covers a busy register; the scoreboard stalls instead.
- Reset mid-operation discards all busy state. Late mc_done_i pulses after reset are ignored (non-busy rule).

Optional Feature:
- HAZARD_PERF_EN defined adds two 32-bit wrap-around counters and ports perf_load_stall_o and perf_sb_stall_o (32 bits each).
  - Each counts cycles with load_stall or sb_stall high.
  - Counters are cleared by reset.
- Undefined: no counters and no ports.

Decomposition:
- hazard_pkg holds:
  - fwd_sel encoding constants: FWD_NONE=0 and FWD_SRC(k)=k+1.
  - A reg_addr_t typedef.
- Sub-module reg_scoreboard holds:
  - The busy vector and outst_cnt with set/clear/full logic.
  - Parameters NUM_REGS and MAX_OUTST.
- The top level keeps forwarding and stall/flush composition.

Test Plan:
- Forward priority: fwd_rd={x5,x5}, fwd_we=2'b11, rs1_ex=5 -> fwd_a_sel=1. Same with we=2'b10 -> 2. rs1_ex=0 -> 0.
- Load-use: load_ex=1, rd_ex=7, rs2_de=7 -> stall_fi/de=1, flush_ex=1 for one cycle. rd_ex=0 -> no stall.
- Scoreboard RAW: mc_start rd=9 at cycle 0, rs1_de=9 at cycles 1..4 -> stall_de=1, flush_ex=1. mc_done rd=9 at cycle 4 -> stall clears at cycle 5.
- Full: 4 starts on x1..x4 (MAX_OUTST=4) -> sb_full=1, and mc_op_de=1 stalls. Simultaneous start x6 + done x1 -> count stays 4.
- Same-cycle start/done on x3 -> busy[3] stays 1; a later single done clears it.
- Redirect with cache miss: redirect_i=1, redirect_reg_i=1, instr_hit=0 -> stall_fi=0, flush_de=1, flush_ex=1. Reset while x8 busy -> busy cleared next cycle, no stall.
